// File: rtl/dma_region_guard.sv
// dma_region_guard: DMA access monitor for hardware-protected memory regions.
// Checks every DMA cycle against up to four inclusive address windows. Each
// window is either no-access or write-protect. A violation raises the
// registered kill request `reset` and holds it for at least KILL_MIN+1
// cycles. Release happens only once the CPU sits at the reset handler.
// Optional macro DMA_GUARD_LOG_EN builds a sticky violation log and a
// saturating violation counter. Without it, the log outputs are tied to zero.
module dma_region_guard #(
    parameter int unsigned NREGIONS      = 2,
    parameter logic [63:0] REGION_BASE   = {16'h0000, 16'h0000, 16'h9000, 16'hA000},
    parameter logic [63:0] REGION_LAST   = {16'h0000, 16'h0000, 16'h901E, 16'hAFFF},
    parameter logic [3:0]  REGION_WO     = 4'b0010,
    parameter logic [15:0] RESET_HANDLER = 16'h0000,
    parameter int unsigned KILL_MIN      = 4
) (
    input  logic        clk,
    input  logic        puc_rst,
    input  logic [15:0] pc,
    input  logic [15:0] dma_addr,
    input  logic        dma_en,
    input  logic        dma_we,
    output logic        reset,
    output logic        viol_valid,
    output logic [1:0]  viol_region,
    output logic [15:0] viol_addr,
    output logic [7:0]  viol_count
);

    localparam logic [3:0] KMIN = 4'(KILL_MIN);

    typedef enum logic {RUN, KILL} state_t;

    state_t     state;
    logic [3:0] kill_cnt;
    logic [3:0] hit;
    logic       viol;

    // Per-region window match; slots at or above NREGIONS never hit
    always_comb begin
        hit = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (i < NREGIONS) begin
                hit[i] = dma_en
                      && (dma_addr >= REGION_BASE[16*i +: 16])
                      && (dma_addr <= REGION_LAST[16*i +: 16])
                      && (!REGION_WO[i] || dma_we);
            end
        end
        viol = |hit;
    end

    // Kill FSM: reset output is registered from the next state
    always_ff @(posedge clk) begin
        if (puc_rst) begin
            state    <= KILL;
            kill_cnt <= KMIN;
            reset    <= 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (viol) begin
                        state    <= KILL;
                        kill_cnt <= '0;
                        reset    <= 1'b1;
                    end else begin
                        reset    <= 1'b0;
                    end
                end
                default: begin
                    if (viol) begin
                        kill_cnt <= '0;
                        reset    <= 1'b1;
                    end else if (kill_cnt == KMIN && pc == RESET_HANDLER) begin
                        state    <= RUN;
                        reset    <= 1'b0;
                    end else begin
                        if (kill_cnt != KMIN) kill_cnt <= kill_cnt + 4'd1;
                        reset    <= 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef DMA_GUARD_LOG_EN
    logic [1:0] hit_idx;

    // Lowest-index hit wins when windows overlap
    always_comb begin
        hit_idx = '0;
        for (int unsigned i = 4; i > 0; i--) begin
            if (hit[i-1]) hit_idx = 2'(i - 1);
        end
    end

    // Sticky log: captured only on RUN->KILL, so hold restarts are not logged
    always_ff @(posedge clk) begin
        if (puc_rst) begin
            viol_valid  <= 1'b0;
            viol_region <= '0;
            viol_addr   <= '0;
            viol_count  <= '0;
        end else if (state == RUN && viol) begin
            viol_valid  <= 1'b1;
            viol_region <= hit_idx;
            viol_addr   <= dma_addr;
            if (viol_count != 8'hFF) viol_count <= viol_count + 8'd1;
        end
    end
`else
    assign viol_valid  = 1'b0;
    assign viol_region = '0;
    assign viol_addr   = '0;
    assign viol_count  = '0;
`endif

endmodule

// File: tb/tb_dma_region_guard.sv
// Testbench for dma_region_guard. It runs directed vectors on the default
// configuration. A second instance with NREGIONS=3 and overlapping windows
// exercises lowest-index selection. Expected log values drop to zero when
// DMA_GUARD_LOG_EN is not defined.
module tb_dma_region_guard;

`ifdef DMA_GUARD_LOG_EN
    localparam bit LOG_ON = 1'b1;
`else
    localparam bit LOG_ON = 1'b0;
`endif

    typedef struct {
        logic        rst;
        logic [15:0] pc;
        logic [15:0] addr;
        logic        en;
        logic        we;
        logic        exp_reset;
        logic        exp_valid;
        logic [1:0]  exp_region;
        logic [15:0] exp_addr;
        logic [7:0]  exp_count;
    } vec_t;

    logic        clk = 1'b0;
    logic        puc_rst;
    logic [15:0] pc, dma_addr;
    logic        dma_en, dma_we;
    logic        reset, viol_valid;
    logic [1:0]  viol_region;
    logic [15:0] viol_addr;
    logic [7:0]  viol_count;

    logic [15:0] pc2, dma_addr2;
    logic        dma_en2, dma_we2;
    logic        reset2, viol_valid2;
    logic [1:0]  viol_region2;
    logic [15:0] viol_addr2;
    logic [7:0]  viol_count2;

    int vectors = 0;
    int miscompares = 0;
    vec_t tbl[$];

    dma_region_guard dut (
        .clk(clk), .puc_rst(puc_rst), .pc(pc), .dma_addr(dma_addr),
        .dma_en(dma_en), .dma_we(dma_we), .reset(reset),
        .viol_valid(viol_valid), .viol_region(viol_region),
        .viol_addr(viol_addr), .viol_count(viol_count)
    );

    dma_region_guard #(
        .NREGIONS(3),
        .REGION_BASE({16'h0000, 16'hA000, 16'h9000, 16'hA000}),
        .REGION_LAST({16'h0000, 16'hA0FF, 16'h901E, 16'hAFFF}),
        .REGION_WO(4'b0010),
        .RESET_HANDLER(16'h0000),
        .KILL_MIN(4)
    ) dut_ovl (
        .clk(clk), .puc_rst(puc_rst), .pc(pc2), .dma_addr(dma_addr2),
        .dma_en(dma_en2), .dma_we(dma_we2), .reset(reset2),
        .viol_valid(viol_valid2), .viol_region(viol_region2),
        .viol_addr(viol_addr2), .viol_count(viol_count2)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic rst, logic [15:0] p, logic [15:0] a,
                                logic en, logic we, logic r, logic v,
                                logic [1:0] rg, logic [15:0] va, logic [7:0] c);
        vec_t t;
        t.rst = rst; t.pc = p; t.addr = a; t.en = en; t.we = we;
        t.exp_reset = r; t.exp_valid = v; t.exp_region = rg;
        t.exp_addr = va; t.exp_count = c;
        return t;
    endfunction

    task automatic check(string name, logic r, logic v, logic [1:0] rg,
                         logic [15:0] va, logic [7:0] c,
                         logic er, logic ev, logic [1:0] erg,
                         logic [15:0] eva, logic [7:0] ec);
        logic        xv;
        logic [1:0]  xrg;
        logic [15:0] xva;
        logic [7:0]  xc;
        xv  = LOG_ON ? ev  : 1'b0;
        xrg = LOG_ON ? erg : 2'd0;
        xva = LOG_ON ? eva : 16'h0000;
        xc  = LOG_ON ? ec  : 8'd0;
        vectors++;
        if (r !== er || v !== xv || rg !== xrg || va !== xva || c !== xc) begin
            miscompares++;
            $display("FAIL %s: got reset=%b valid=%b region=%0d addr=%h count=%0d, want reset=%b valid=%b region=%0d addr=%h count=%0d",
                     name, r, v, rg, va, c, er, xv, xrg, xva, xc);
        end
    endtask

    task automatic drive(logic rst, logic [15:0] p, logic [15:0] a, logic en, logic we);
        puc_rst = rst; pc = p; dma_addr = a; dma_en = en; dma_we = we;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // rst, pc, addr, en, we | reset, valid, region, addr, count
        tbl.push_back(mk(1, 16'h0000, 16'h0000, 0, 0, 1, 0, 0, 16'h0000, 0)); // 0 power-up reset
        tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 0)); // 1 immediate release
        tbl.push_back(mk(0, 16'h0000, 16'hA000, 1, 0, 1, 1, 0, 16'hA000, 1)); // 2 read region0
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 1, 1, 0, 16'hA000, 1)); // 3-6 hold
        tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 0, 1, 0, 16'hA000, 1)); // 7 release
        tbl.push_back(mk(0, 16'h0000, 16'h9010, 1, 0, 0, 1, 0, 16'hA000, 1)); // 8 read of WO region ok
        tbl.push_back(mk(0, 16'h0000, 16'h901E, 1, 1, 1, 1, 1, 16'h901E, 2)); // 9 write WO last addr
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 1, 1, 1, 16'h901E, 2)); // 10-13
        tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 0, 1, 1, 16'h901E, 2)); // 14 release
        tbl.push_back(mk(0, 16'h0000, 16'h9020, 1, 1, 0, 1, 1, 16'h901E, 2)); // 15 past last
        tbl.push_back(mk(0, 16'h0000, 16'hA000, 0, 1, 0, 1, 1, 16'h901E, 2)); // 16 we without en
        tbl.push_back(mk(0, 16'h0000, 16'hA100, 1, 1, 1, 1, 0, 16'hA100, 3)); // 17 violation
        tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 1, 1, 0, 16'hA100, 3)); // 18
        tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 1, 1, 0, 16'hA100, 3)); // 19
        tbl.push_back(mk(0, 16'h0000, 16'hAFFF, 1, 0, 1, 1, 0, 16'hA100, 3)); // 20 restart, not logged
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 1, 1, 0, 16'hA100, 3)); // 21-24
        tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 0, 1, 0, 16'hA100, 3)); // 25 release
        tbl.push_back(mk(0, 16'hE000, 16'hA000, 1, 0, 1, 1, 0, 16'hA000, 4)); // 26 violation
        for (int i = 0; i < 6; i++)
            tbl.push_back(mk(0, 16'hE000, 16'h0000, 0, 0, 1, 1, 0, 16'hA000, 4)); // 27-32 pc gate
        tbl.push_back(mk(0, 16'h0000, 16'hA800, 1, 0, 1, 1, 0, 16'hA000, 4)); // 33 pc ok but viol
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 1, 1, 0, 16'hA000, 4)); // 34-37
        tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 0, 1, 0, 16'hA000, 4)); // 38 release
        tbl.push_back(mk(1, 16'h0000, 16'hA000, 1, 0, 1, 0, 0, 16'h0000, 0)); // 39 reset beats viol
        tbl.push_back(mk(0, 16'hE000, 16'h0000, 0, 0, 1, 0, 0, 16'h0000, 0)); // 40 wait for pc
        tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 0)); // 41 release
        tbl.push_back(mk(0, 16'h0000, 16'h8FFF, 1, 1, 0, 0, 0, 16'h0000, 0)); // 42 below base
        tbl.push_back(mk(0, 16'h0000, 16'h9000, 1, 1, 1, 1, 1, 16'h9000, 1)); // 43 at base
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 1, 1, 1, 16'h9000, 1)); // 44-47
        tbl.push_back(mk(0, 16'h0000, 16'h0000, 0, 0, 0, 1, 1, 16'h9000, 1)); // 48 release
        tbl.push_back(mk(0, 16'h0000, 16'h0000, 1, 1, 0, 1, 1, 16'h9000, 1)); // 49 slot 2 inactive

        pc2 = 16'h0000; dma_addr2 = 16'h0000; dma_en2 = 1'b0; dma_we2 = 1'b0;

        foreach (tbl[k]) begin
            drive(tbl[k].rst, tbl[k].pc, tbl[k].addr, tbl[k].en, tbl[k].we);
            check($sformatf("vec%0d", k), reset, viol_valid, viol_region, viol_addr, viol_count,
                  tbl[k].exp_reset, tbl[k].exp_valid, tbl[k].exp_region,
                  tbl[k].exp_addr, tbl[k].exp_count);
        end

        // Counter saturation: 260 further kill/release rounds
        for (int n = 0; n < 260; n++) begin
            drive(0, 16'h0000, 16'hA000, 1, 0);
            for (int j = 0; j < 5; j++) drive(0, 16'h0000, 16'h0000, 0, 0);
            if (n == 0)
                check("count_step", reset, viol_valid, viol_region, viol_addr, viol_count,
                      0, 1, 0, 16'hA000, 8'd2);
        end
        check("count_sat", reset, viol_valid, viol_region, viol_addr, viol_count,
              0, 1, 0, 16'hA000, 8'd255);

        // Overlap instance: slot 3 inactive, then overlapping hit
        dma_addr2 = 16'h0000; dma_en2 = 1'b1; dma_we2 = 1'b1;
        @(posedge clk); #1;
        check("ovl_slot3_off", reset2, viol_valid2, viol_region2, viol_addr2, viol_count2,
              0, 0, 0, 16'h0000, 0);
        dma_addr2 = 16'hA010; dma_we2 = 1'b0;
        @(posedge clk); #1;
        check("ovl_lowest", reset2, viol_valid2, viol_region2, viol_addr2, viol_count2,
              1, 1, 0, 16'hA010, 1);
        dma_en2 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
